wb_ram_slave: RTL and testbench

Wishbone classic-cycle slave that answers the CPU's 32-bit instruction-side or data-side Wishbone master ports with a single-port on-chip RAM. It sits on the SoC side of the core, one instance per bus, and supports configurable wait states and byte-lane writes. It guarantees exactly one acknowledge per request and handles aborted cycles cleanly.

---
 rtl/wb_ram_slave.sv | 123 ++++++++++++
 tb/tb_wb_ram_slave.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave backed by a single-port RAM, with programmable wait states and byte lanes.
// Define WB_RAM_ERR_EN to add wb_err_o and error-terminate requests outside the RAM window.
module wb_ram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_addr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
`ifdef WB_RAM_ERR_EN
  output logic        wb_err_o,
`endif
  output logic        wb_ack_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD = 4'(WS_M1);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [31:0]             dat_q;
  logic                    oor_q;
  logic                    err_q;
  logic [31:0]             mem_q [2**ADDR_WIDTH];

  logic                    req;
  logic                    is_idle;
  logic                    oor_in;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic                    cur_we;
  logic [3:0]              cur_sel;
  logic [31:0]             cur_dat;
  logic                    cur_oor;

  assign req     = wb_cyc_i & wb_stb_i;
  assign is_idle = (state_q == S_IDLE);

`ifdef WB_RAM_ERR_EN
  assign oor_in   = |wb_addr_i[31:ADDR_WIDTH+2];
  assign wb_err_o = err_q;
  logic unused_bits;
  assign unused_bits = ^wb_addr_i[1:0];
`else
  assign oor_in = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{wb_addr_i[31:ADDR_WIDTH+2], wb_addr_i[1:0], err_q, oor_q};
`endif

  // With zero wait states the commit happens on the accepting edge, so use the live bus.
  assign cur_idx = is_idle ? wb_addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign cur_we  = is_idle ? wb_we_i   : we_q;
  assign cur_sel = is_idle ? wb_sel_i  : sel_q;
  assign cur_dat = is_idle ? wb_data_i : dat_q;
  assign cur_oor = is_idle ? oor_in    : oor_q;

  // Edge entering ACK: the only edge where the RAM is read or written.
  assign commit = !rst && req &&
                  ((is_idle && (WAIT_STATES == 0)) || (state_q == S_WAIT && cnt_q == 4'd0));

  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem_q[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_data_o <= 32'd0;
    end else begin
      wb_ack_o  <= commit && !cur_oor;
      err_q     <= commit && cur_oor;
      wb_data_o <= (commit && !cur_we && !cur_oor) ? mem_q[cur_idx] : 32'd0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q <= wb_addr_i[ADDR_WIDTH+1:2];
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_data_i;
            oor_q <= oor_in;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!req)                state_q <= S_IDLE;
          else if (cnt_q == 4'd0)  state_q <= S_ACK;
          else                     cnt_q   <= cnt_q - 4'd1;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench: three slaves with 1, 3 and 2 wait states sharing clock and reset.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cyc, stb, we, ack, err;
  logic [31:0] addr [3];
  logic [3:0]  sel  [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];

  int nassert = 0;
  int nfail   = 0;
  int nack, first, nerr, ferr, stray;
  logic [31:0] rd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    wb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(WS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wb_cyc_i  (cyc[g]),
      .wb_stb_i  (stb[g]),
      .wb_we_i   (we[g]),
      .wb_addr_i (addr[g]),
      .wb_sel_i  (sel[g]),
      .wb_data_i (wdat[g]),
      .wb_data_o (rdat[g]),
`ifdef WB_RAM_ERR_EN
      .wb_err_o  (err[g]),
`endif
      .wb_ack_o  (ack[g])
    );
`ifndef WB_RAM_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer on slave i; the master drops cyc/stb at the negedge numbered 'hold'.
  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int hold);
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; wdat[i] = d;
    nack = 0; first = -1; nerr = 0; ferr = -1; stray = 0; rd = 32'd0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (ack[i]) begin
        nack++;
        if (first < 0) first = k;
        rd = rdat[i];
      end else if (rdat[i] != 32'd0) stray++;
      if (err[i]) begin
        nerr++;
        if (ferr < 0) ferr = k;
      end
      if (k == 1) wdat[i] = ~d;
      if (k == hold) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
    end
  endtask

  initial begin
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 32'd0; sel[i] = 4'd0; wdat[i] = 32'd0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cyc[i] = 1'($urandom); stb[i] = 1'($urandom); we[i] = 1'($urandom);
        addr[i] = $urandom; sel[i] = 4'($urandom); wdat[i] = $urandom;
      end
    end
    @(negedge clk);
    chk("rst ack0", {31'd0, ack[0]}, 32'd0);
    chk("rst ack1", {31'd0, ack[1]}, 32'd0);
    chk("rst ack2", {31'd0, ack[2]}, 32'd0);
    chk("rst dat0", rdat[0], 32'd0);
    chk("rst dat1", rdat[1], 32'd0);
    chk("rst dat2", rdat[2], 32'd0);
    chk("rst err", {29'd0, err}, 32'd0);
    cyc = '0; stb = '0;
    @(negedge clk);
    rst = 1'b0;

    // WS=1: full write then read
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2);
    chk("wr nack", 32'(nack), 32'd1);
    chk("wr lat", 32'(first), 32'd2);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, 2);
    chk("rd nack", 32'(nack), 32'd1);
    chk("rd lat", 32'(first), 32'd2);
    chk("rd data", rd, 32'hDEADBEEF);
    chk("rd stray", 32'(stray), 32'd0);

    // byte lane write and sel=0 write
    xfer(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 2);
    xfer(0, 1'b0, 32'h10, 4'b0000, 32'd0, 2);
    chk("lane data", rd, 32'hDEADAAEF);
    chk("lane sel0 rd ack", 32'(nack), 32'd1);
    xfer(0, 1'b1, 32'h13, 4'b0000, 32'hFFFFFFFF, 2);
    chk("sel0 nack", 32'(nack), 32'd1);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, 2);
    chk("sel0 data", rd, 32'hDEADAAEF);

    // WS=3: abort and held strobe
    xfer(1, 1'b1, 32'h20, 4'hF, 32'd0, 4);
    chk("ws3 nack", 32'(nack), 32'd1);
    chk("ws3 lat", 32'(first), 32'd4);
    xfer(1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1);
    chk("abort nack", 32'(nack), 32'd0);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'd0, 4);
    chk("abort data", rd, 32'd0);
    chk("abort rd ack", 32'(nack), 32'd1);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'd0, 6);
    chk("held nack", 32'(nack), 32'd1);
    chk("held lat", 32'(first), 32'd4);

    // out-of-range address on WS=1
    xfer(0, 1'b1, 32'h4010, 4'hF, 32'h11111111, 2);
`ifdef WB_RAM_ERR_EN
    chk("oor nack", 32'(nack), 32'd0);
    chk("oor nerr", 32'(nerr), 32'd1);
    chk("oor err lat", 32'(ferr), 32'd2);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, 2);
    chk("oor keep", rd, 32'hDEADAAEF);
`else
    chk("alias nack", 32'(nack), 32'd1);
    chk("alias nerr", 32'(nerr), 32'd0);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, 2);
    chk("alias data", rd, 32'h11111111);
`endif

    // WS=2: reset during WAIT
    xfer(2, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 3);
    chk("ws2 lat", 32'(first), 32'd3);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h30; sel[2] = 4'hF;
    wdat[2] = 32'h0BADBEEF;
    nack = 0;
    @(negedge clk);
    if (ack[2]) nack++;
    rst = 1'b1;
    @(negedge clk);
    if (ack[2]) nack++;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack[2]) nack++;
    end
    chk("rstmid nack", 32'(nack), 32'd0);
    xfer(2, 1'b0, 32'h30, 4'hF, 32'd0, 3);
    chk("rstmid data", rd, 32'hCAFEF00D);
    chk("rstmid lat", 32'(first), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
